mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single memory-controller port between the instruction cache (read-only) and the data cache (read/write).
It grants one requester at a time, latches the granted requester's address and burst length, and counts mem_valid beats to the end of the burst.
It routes read data and beat acknowledges back to the granted requester only, and resolves conflicts round-robin.
It sits between icache/dcache and the memory controller.

Parameters:
ADDRBITS, 32, address width
DATABITS, 32, data width
BURSTBITS, 16, burst length field width

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ic_addr  in  ADDRBITS  icache request start address
ic_rdreq  in  1  icache read request, held until ic_done
ic_burstlen  in  BURSTBITS  icache beats requested
ic_dataout  out  DATABITS  read data to icache
ic_valid  out  1  icache beat strobe
ic_done  out  1  icache last-beat strobe
dc_addr  in  ADDRBITS  dcache request start address
dc_datain  in  DATABITS  dcache write data, current beat
dc_rdreq  in  1  dcache read request, held until dc_done
dc_wrreq  in  1  dcache write request, held until dc_done
dc_burstlen  in  BURSTBITS  dcache beats requested
dc_dataout  out  DATABITS  read data to dcache
dc_valid  out  1  dcache beat strobe (read data valid / write beat accepted)
dc_done  out  1  dcache last-beat strobe
mem_addr  out  ADDRBITS  latched address to controller
mem_in  out  DATABITS  write data to controller
mem_rdreq  out  1  read request to controller
mem_wrreq  out  1  write request to controller
mem_burstlen  out  BURSTBITS  latched burst length
mem_out  in  DATABITS  read data from controller
mem_valid  in  1  controller beat strobe

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, TURN.
- Reset (asynchronous): state=IDLE, beat counter=0, rr_last=D (so icache wins the first conflict).
  - mem_rdreq, mem_wrreq, mem_addr, mem_burstlen are all 0.
  - All client outputs are 0.
- IDLE, only ic_rdreq high: go to BUSY_I at the next edge.
- IDLE, only dc_rdreq or dc_wrreq high: go to BUSY_D at the next edge.
- IDLE, both requesters high: grant the one not equal to rr_last. rr_last is updated on every grant.
- On grant, latch into registers: addr, burstlen, and direction (dcache only).
  - A latched burstlen of 0 is treated as 1.
  - dc_rdreq and dc_wrreq both high: treated as a write.
- Grant latency: mem_rdreq/mem_wrreq rise exactly 1 cycle after a request is seen in IDLE.
- BUSY_x: mem_addr, mem_burstlen, mem_rdreq/mem_wrreq are held constant (registered). Client inputs are not re-sampled.
- Each cycle with mem_valid=1 increments the beat counter (BURSTBITS wide).
- Read data path is combinational passthrough:
  - ic_dataout = mem_out, ic_valid = mem_valid, both gated to BUSY_I.
  - dc_dataout and dc_valid likewise, gated to BUSY_D. Ungranted outputs are 0.
- Write data: mem_in = dc_datain combinationally in BUSY_D write, 0 otherwise.
  - dc_valid marks the accepted beat; the client presents the next word in the following cycle.
- Last beat: mem_valid=1 with counter == burstlen-1.
  - The granted done output pulses in that cycle.
  - The next edge goes to TURN, clears the counter, and deasserts mem_rdreq/mem_wrreq.
- TURN: 1 cycle with no request outputs, no mem_valid forwarding, and requests ignored, then IDLE. Clients drop their request on done; TURN guarantees no duplicate grant.
- Back-to-back bursts: gap is 2 cycles (mem req low in TURN and IDLE), then the next request is asserted.
- mem_valid in IDLE/TURN: ignored, no strobes to clients.
- Request dropped mid-burst: ignored. The burst runs to completion and strobes are still produced.
- Reset mid-burst: immediate return to IDLE with all outputs 0. rr_last returns to D.

Test Plan:
- icache alone: ic_addr=0x100, ic_burstlen=4, 4 mem_valid beats -> mem_rdreq high 1 cycle after request with mem_addr=0x100 and mem_burstlen=4; ic_valid 4 times; ic_done on beat 4; mem_rdreq low the next cycle.
- Simultaneous ic_rdreq and dc_rdreq after reset -> icache granted first. Then dcache is granted after icache completes plus TURN. A third simultaneous pair grants icache again (alternation).
- dcache write: burstlen=2, datain 0xDEADBEEF then 0xCAFEF00D advanced on dc_valid -> mem_wrreq high, mem_in matches each beat, dc_done on beat 2, mem_rdreq stays 0.
- burstlen=0 from dcache read -> mem_burstlen=1 is latched; a single beat produces dc_valid and dc_done together.
- Stray mem_valid in IDLE, and mem_valid during BUSY_I -> no client strobes in IDLE; no dc_valid during BUSY_I.
- reset_n low mid-burst after beat 2 of 4 -> all outputs 0 immediately. After release with ic_rdreq held, a fresh burst is granted with the counter restarted at 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory-controller port between icache (read-only) and dcache (read/write).
// Latches the granted request and counts mem_valid beats to the end of the burst.
module mem_arbiter #(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = 32,
  parameter int BURSTBITS = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // icache
  input  logic [ADDRBITS-1:0]  ic_addr,
  input  logic                 ic_rdreq,
  input  logic [BURSTBITS-1:0] ic_burstlen,
  output logic [DATABITS-1:0]  ic_dataout,
  output logic                 ic_valid,
  output logic                 ic_done,
  // dcache
  input  logic [ADDRBITS-1:0]  dc_addr,
  input  logic [DATABITS-1:0]  dc_datain,
  input  logic                 dc_rdreq,
  input  logic                 dc_wrreq,
  input  logic [BURSTBITS-1:0] dc_burstlen,
  output logic [DATABITS-1:0]  dc_dataout,
  output logic                 dc_valid,
  output logic                 dc_done,
  // memory controller
  output logic [ADDRBITS-1:0]  mem_addr,
  output logic [DATABITS-1:0]  mem_in,
  output logic                 mem_rdreq,
  output logic                 mem_wrreq,
  output logic [BURSTBITS-1:0] mem_burstlen,
  input  logic [DATABITS-1:0]  mem_out,
  input  logic                 mem_valid
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, TURN} state_t;

  state_t               state_q, state_d;
  logic                 rr_last_q, rr_last_d;   // 1 = dcache was granted last
  logic [ADDRBITS-1:0]  addr_q, addr_d;
  logic [BURSTBITS-1:0] burst_q, burst_d;
  logic [BURSTBITS-1:0] cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic                 rdreq_q, rdreq_d;
  logic                 wrreq_q, wrreq_d;

  logic                 ic_req, dc_req, grant_dc, last_beat;
  logic [BURSTBITS-1:0] req_len;

  assign ic_req    = ic_rdreq;
  assign dc_req    = dc_rdreq | dc_wrreq;
  // On conflict the requester that was not granted last wins.
  assign grant_dc  = dc_req & (~ic_req | ~rr_last_q);
  assign req_len   = grant_dc ? dc_burstlen : ic_burstlen;
  assign last_beat = mem_valid && (cnt_q == burst_q - BURSTBITS'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      addr_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      rdreq_q   <= 1'b0;
      wrreq_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      addr_q    <= addr_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      rdreq_q   <= rdreq_d;
      wrreq_q   <= wrreq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    addr_d    = addr_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    rdreq_d   = rdreq_q;
    wrreq_d   = wrreq_q;
    case (state_q)
      IDLE: begin
        if (ic_req || dc_req) begin
          state_d   = grant_dc ? BUSY_D : BUSY_I;
          rr_last_d = grant_dc;
          addr_d    = grant_dc ? dc_addr : ic_addr;
          burst_d   = (req_len == '0) ? BURSTBITS'(1) : req_len;
          wr_d      = grant_dc & dc_wrreq;
          rdreq_d   = ~(grant_dc & dc_wrreq);
          wrreq_d   = grant_dc & dc_wrreq;
          cnt_d     = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_valid) begin
          cnt_d = cnt_q + BURSTBITS'(1);
        end
        if (last_beat) begin
          state_d = TURN;
          cnt_d   = '0;
          rdreq_d = 1'b0;
          wrreq_d = 1'b0;
        end
      end
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr     = addr_q;
  assign mem_burstlen = burst_q;
  assign mem_rdreq    = rdreq_q;
  assign mem_wrreq    = wrreq_q;
  assign mem_in       = (state_q == BUSY_D && wr_q) ? dc_datain : '0;

  assign ic_valid   = (state_q == BUSY_I) & mem_valid;
  assign ic_dataout = (state_q == BUSY_I) ? mem_out : '0;
  assign ic_done    = (state_q == BUSY_I) & last_beat;

  assign dc_valid   = (state_q == BUSY_D) & mem_valid;
  assign dc_dataout = (state_q == BUSY_D) ? mem_out : '0;
  assign dc_done    = (state_q == BUSY_D) & last_beat;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected client beats, a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ic_addr, dc_addr, dc_datain, mem_out;
  logic [15:0] ic_burstlen, dc_burstlen;
  logic        ic_rdreq, dc_rdreq, dc_wrreq, mem_valid;
  logic [31:0] ic_dataout, dc_dataout, mem_addr, mem_in;
  logic        ic_valid, ic_done, dc_valid, dc_done, mem_rdreq, mem_wrreq;
  logic [15:0] mem_burstlen;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    bit          who_d;
    bit          wr;
    logic [31:0] data;
    bit          done;
  } exp_t;
  exp_t exp_q[$];

  mem_arbiter #(.ADDRBITS(32), .DATABITS(32), .BURSTBITS(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ic_addr(ic_addr), .ic_rdreq(ic_rdreq), .ic_burstlen(ic_burstlen),
    .ic_dataout(ic_dataout), .ic_valid(ic_valid), .ic_done(ic_done),
    .dc_addr(dc_addr), .dc_datain(dc_datain), .dc_rdreq(dc_rdreq), .dc_wrreq(dc_wrreq),
    .dc_burstlen(dc_burstlen), .dc_dataout(dc_dataout), .dc_valid(dc_valid), .dc_done(dc_done),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq),
    .mem_burstlen(mem_burstlen), .mem_out(mem_out), .mem_valid(mem_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One mem_valid beat; expected client response goes to the scoreboard.
  task automatic beat(input bit who_d, input bit wr, input logic [31:0] data, input bit done);
    exp_t e;
    if (wr) begin dc_datain = data; mem_out = '0; end
    else mem_out = data;
    mem_valid = 1'b1;
    e.who_d = who_d; e.wr = wr; e.data = data; e.done = done;
    exp_q.push_back(e);
    step();
    mem_valid = 1'b0;
    mem_out = '0;
  endtask

  always @(negedge clk) begin
    if (ic_valid || dc_valid || ic_done || dc_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {ic_valid, dc_valid, ic_done, dc_done}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("beat %s %s data=%h done=%0d", e.who_d ? "dc" : "ic", e.wr ? "wr" : "rd", e.data, e.done);
        check("beat_sel", {ic_valid, dc_valid}, e.who_d ? 2'b01 : 2'b10);
        check("beat_done", {ic_done, dc_done}, e.done ? (e.who_d ? 2'b01 : 2'b10) : 2'b00);
        check("beat_req", {mem_rdreq, mem_wrreq}, e.wr ? 2'b01 : 2'b10);
        if (e.wr) check("beat_mem_in", mem_in, e.data);
        else check("beat_rdata", e.who_d ? dc_dataout : ic_dataout, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    ic_addr = '0; ic_rdreq = 1'b0; ic_burstlen = '0;
    dc_addr = '0; dc_datain = '0; dc_rdreq = 1'b0; dc_wrreq = 1'b0; dc_burstlen = '0;
    mem_out = '0; mem_valid = 1'b0;
    #3;
    check("rst_mem", {mem_rdreq, mem_wrreq, mem_addr, mem_burstlen}, 0);
    check("rst_client", {ic_valid, ic_done, dc_valid, dc_done, ic_dataout, dc_dataout}, 0);
    step();
    reset_n = 1'b1;
    step();

    // Conflict after reset: icache first, then dcache after TURN, then icache again
    ic_rdreq = 1'b1; ic_addr = 32'h1000; ic_burstlen = 16'd2;
    dc_rdreq = 1'b1; dc_addr = 32'h2000; dc_burstlen = 16'd1;
    check("arb_pre_grant", mem_rdreq, 1'b0);
    step();
    check("arb1_req", mem_rdreq, 1'b1);
    check("arb1_addr", mem_addr, 32'h1000);
    beat(1'b0, 1'b0, 32'hA0A0_0001, 1'b0);
    beat(1'b0, 1'b0, 32'hA0A0_0002, 1'b1);
    ic_rdreq = 1'b0;
    check("arb_turn_req", mem_rdreq, 1'b0);
    step();
    check("arb_idle_req", mem_rdreq, 1'b0);
    step();
    check("arb2_req", mem_rdreq, 1'b1);
    check("arb2_addr", mem_addr, 32'h2000);
    beat(1'b1, 1'b0, 32'hB0B0_0001, 1'b1);
    dc_rdreq = 1'b0;
    step();
    ic_rdreq = 1'b1; ic_addr = 32'h1100;
    dc_rdreq = 1'b1;
    step();
    check("arb3_addr", mem_addr, 32'h1100);
    beat(1'b0, 1'b0, 32'hA1A1_0001, 1'b0);
    beat(1'b0, 1'b0, 32'hA1A1_0002, 1'b1);
    ic_rdreq = 1'b0; dc_rdreq = 1'b0;
    step();

    // icache alone, 4 beats
    ic_rdreq = 1'b1; ic_addr = 32'h100; ic_burstlen = 16'd4;
    step();
    check("ic_req", {mem_rdreq, mem_wrreq}, 2'b10);
    check("ic_addr", mem_addr, 32'h100);
    check("ic_blen", mem_burstlen, 16'd4);
    for (int k = 0; k < 4; k++) beat(1'b0, 1'b0, 32'h1111_0000 + k, k == 3);
    ic_rdreq = 1'b0;
    check("ic_req_drop", mem_rdreq, 1'b0);
    step();

    // dcache write burst of 2
    dc_wrreq = 1'b1; dc_addr = 32'h200; dc_burstlen = 16'd2; dc_datain = 32'hDEADBEEF;
    step();
    check("wr_req", {mem_rdreq, mem_wrreq}, 2'b01);
    check("wr_addr", mem_addr, 32'h200);
    check("wr_blen", mem_burstlen, 16'd2);
    beat(1'b1, 1'b1, 32'hDEADBEEF, 1'b0);
    beat(1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    dc_wrreq = 1'b0; dc_datain = '0;
    check("wr_req_drop", {mem_rdreq, mem_wrreq}, 2'b00);
    step();

    // dcache read with burstlen 0
    dc_rdreq = 1'b1; dc_addr = 32'h300; dc_burstlen = 16'd0;
    step();
    check("bl0_blen", mem_burstlen, 16'd1);
    check("bl0_req", {mem_rdreq, mem_wrreq}, 2'b10);
    beat(1'b1, 1'b0, 32'h0BAD_F00D, 1'b1);
    dc_rdreq = 1'b0;
    step();

    // Stray mem_valid in IDLE
    mem_valid = 1'b1; mem_out = 32'h5555_5555;
    @(negedge clk);
    check("idle_strobe", {ic_valid, dc_valid, ic_done, dc_done}, 4'b0000);
    check("idle_data", {ic_dataout, dc_dataout}, 64'h0);
    step();
    mem_valid = 1'b0; mem_out = '0;
    step();

    // Reset mid-burst after beat 2 of 4; rr_last must return to dcache
    ic_rdreq = 1'b1; ic_addr = 32'h400; ic_burstlen = 16'd4;
    step();
    beat(1'b0, 1'b0, 32'h4444_0000, 1'b0);
    beat(1'b0, 1'b0, 32'h4444_0001, 1'b0);
    mem_valid = 1'b1; mem_out = 32'h9999_9999;
    reset_n = 1'b0;
    #1;
    check("rst_mid_mem", {mem_rdreq, mem_wrreq, mem_addr, mem_burstlen}, 0);
    check("rst_mid_client", {ic_valid, ic_done, dc_valid, dc_done, ic_dataout}, 0);
    step();
    mem_valid = 1'b0; mem_out = '0;
    dc_rdreq = 1'b1; dc_addr = 32'h500; dc_burstlen = 16'd1;
    reset_n = 1'b1;
    step();
    check("post_rst_addr", mem_addr, 32'h400);
    for (int k = 0; k < 4; k++) beat(1'b0, 1'b0, 32'h4545_0000 + k, k == 3);
    ic_rdreq = 1'b0;
    step();
    step();
    check("post_rst_dc_addr", mem_addr, 32'h500);
    beat(1'b1, 1'b0, 32'h5151_0000, 1'b1);
    dc_rdreq = 1'b0;
    step();
    step();

    check("queue_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
